booth_seq_mul: RTL and testbench

- Parametrised, multi-cycle radix-4 Booth multiplier for the CPU datapath's MUL path.
- Successor to the single-cycle combinational multiplier:
  - generic operand width;
  - signed/unsigned mode;
  - start/busy/done handshake;
  - retires one Booth digit per clock, trading latency for area.
- Sits between the register-file operand latches and the HI/LO result registers. The control unit stalls on busy.

---
 rtl/booth_seq_mul.sv | 163 ++++++++++++++++
 tb/tb_booth_seq_mul.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mul.sv
// booth_seq_mul: multi-cycle radix-4 Booth multiplier for the MUL path.
// Retires one Booth digit per clock. Operands are captured on start in IDLE.
// The product appears on z together with a one-cycle done pulse.
//
// Parameters:
//   WIDTH   operand width (even, >= 4); the product is 2*WIDTH bits
//   DIGITS  WIDTH/2+1 Booth digits (derived, local)
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset; aborts any operation in flight
//   start      request, sampled only in IDLE
//   is_signed  1 = two's-complement operands, 0 = unsigned (captured with start)
//   Q          multiplicand (captured with start)
//   b          multiplier   (captured with start)
//   busy       high while digits are being retired
//   done       one-cycle pulse when z is updated
//   z          product; holds the last result until the next done
//
// Optional feature (compile-time macro BOOTH_SEQ_MUL_EARLY_TERM_EN):
//   The block leaves RUN early when all remaining multiplier bits are equal.
//   Remaining digits are then all zero, so the result does not change.
module booth_seq_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam int unsigned DIGITS = WIDTH / 2 + 1;
  localparam int unsigned ACC_W  = 2 * WIDTH + 4;
  // Extended multiplier (WIDTH+2) plus the implicit zero below bit 0.
  localparam int unsigned RSH_W  = WIDTH + 3;
  localparam int unsigned CNT_W  = $clog2(DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   m_q, m_d;     // multiplicand, pre-shifted by 2i
  logic [RSH_W-1:0]   r_q, r_d;     // multiplier, window always in [2:0]
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_d;
  logic               done_d;
  logic [2*WIDTH-1:0] z_d;

  logic [ACC_W-1:0]   m2;
  logic [ACC_W-1:0]   pp;
  logic               last_digit;
  logic               rest_uniform;

  assign m2         = {m_q[ACC_W-2:0], 1'b0};
  assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

  // r_q is shifted arithmetically, so the fill bits copy the top multiplier
  // bit and r_q[RSH_W-1:2] covers exactly the not-yet-consumed bits.
`ifdef BOOTH_SEQ_MUL_EARLY_TERM_EN
  assign rest_uniform = (r_q[RSH_W-1:2] == '0) || (&r_q[RSH_W-1:2]);
`else
  assign rest_uniform = 1'b0;
`endif

  // Radix-4 Booth recoding of the current 3-bit window.
  always_comb begin
    pp = '0;
    unique case (r_q[2:0])
      3'b001, 3'b010: pp = m_q;
      3'b011:         pp = m2;
      3'b100:         pp = ~m2 + ACC_W'(1);
      3'b101, 3'b110: pp = ~m_q + ACC_W'(1);
      default:        pp = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    done_d  = 1'b0;
    z_d     = z;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = {{(ACC_W - WIDTH){is_signed & Q[WIDTH-1]}}, Q};
          r_d     = {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        acc_d = acc_q + pp;
        m_d   = {m_q[ACC_W-3:0], 2'b00};
        r_d   = {{2{r_q[RSH_W-1]}}, r_q[RSH_W-1:2]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_digit || rest_uniform) begin
          busy_d  = 1'b0;
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        z_d     = acc_q[2*WIDTH-1:0];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      m_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
      busy  <= busy_d;
      done  <= done_d;
      z     <= z_d;
    end
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: self-checking bench for booth_seq_mul at WIDTH=32 and WIDTH=8.
module tb_booth_seq_mul;

  localparam int unsigned W32 = 32;
  localparam int unsigned W8  = 8;
  localparam int FULL32 = 18;   // start-sample edge to done, WIDTH=32
  localparam int FULL8  = 6;    // same for WIDTH=8
`ifdef BOOTH_SEQ_MUL_EARLY_TERM_EN
  localparam int LAT32 = -1;
  localparam int LAT8  = -1;
`else
  localparam int LAT32 = FULL32;
  localparam int LAT8  = FULL8;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic              start32 = 1'b0, sg32 = 1'b0;
  logic [W32-1:0]    q32 = '0, b32 = '0;
  logic              busy32, done32;
  logic [2*W32-1:0]  z32;

  logic              start8 = 1'b0, sg8 = 1'b0;
  logic [W8-1:0]     q8 = '0, b8 = '0;
  logic              busy8, done8;
  logic [2*W8-1:0]   z8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb32[$];
  logic [15:0] sb8[$];

  always #5 clk = ~clk;

  booth_seq_mul #(.WIDTH(W32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .is_signed(sg32),
    .Q(q32), .b(b32), .busy(busy32), .done(done32), .z(z32)
  );

  booth_seq_mul #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .is_signed(sg8),
    .Q(q8), .b(b8), .busy(busy8), .done(done8), .z(z8)
  );

  function automatic logic [63:0] ref32(input logic [31:0] qv, input logic [31:0] bv,
                                        input logic sg);
    logic [63:0] qe, be;
    qe = sg ? {{32{qv[31]}}, qv} : {32'b0, qv};
    be = sg ? {{32{bv[31]}}, bv} : {32'b0, bv};
    return qe * be;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] qv, input logic [7:0] bv,
                                       input logic sg);
    logic [15:0] qe, be;
    qe = sg ? {{8{qv[7]}}, qv} : {8'b0, qv};
    be = sg ? {{8{bv[7]}}, bv} : {8'b0, bv};
    return qe * be;
  endfunction

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One 32-bit operation; lat = edges from start sample to done.
  task automatic op32(input string tag, input logic [31:0] qv, input logic [31:0] bv,
                      input logic sg, input logic [63:0] exp_z, input int exp_lat,
                      input bit scramble, output int lat);
    int n, bcnt;
    @(negedge clk);
    q32 = qv; b32 = bv; sg32 = sg; start32 = 1'b1;
    sb32.push_back(exp_z);
    @(negedge clk);
    start32 = 1'b0;
    n = 0; bcnt = 0;
    while (done32 !== 1'b1 && n < 60) begin
      if (busy32 === 1'b1) bcnt++;
      if (scramble) begin
        q32 = $urandom; b32 = $urandom; sg32 = ~sg32;
      end
      @(negedge clk);
      n++;
    end
    lat = n;
    check64({tag, "/done"}, 64'(done32), 64'd1);
    check64({tag, "/z"}, z32, sb32.pop_front());
    if (exp_lat > 0) begin
      check_int({tag, "/latency"}, n, exp_lat);
      check_int({tag, "/busy_cycles"}, bcnt, exp_lat - 1);
    end
    @(negedge clk);
    check64({tag, "/done_pulse"}, 64'(done32), 64'd0);
  endtask

  task automatic op8(input logic [7:0] qv, input logic [7:0] bv, input logic sg);
    int n;
    @(negedge clk);
    q8 = qv; b8 = bv; sg8 = sg; start8 = 1'b1;
    sb8.push_back(ref8(qv, bv, sg));
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check64($sformatf("w8 %h*%h s%0d /z", qv, bv, sg), 64'(z8), 64'(sb8.pop_front()));
    if (LAT8 > 0) check_int($sformatf("w8 %h*%h /latency", qv, bv), n, LAT8);
  endtask

  initial begin
    int lat, n, seen;
    logic [31:0] rq, rb;
    logic [7:0] corners [6];
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55};

    // Reset state
    repeat (3) @(negedge clk);
    check64("rst/busy32", 64'(busy32), 64'd0);
    check64("rst/done32", 64'(done32), 64'd0);
    check64("rst/z32", z32, 64'd0);
    check64("rst/z8", 64'(z8), 64'd0);
    reset_n = 1'b1;

    // Directed products
    op32("s7xm3", 32'h00000007, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFEB, LAT32, 1'b0, lat);
    op32("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, LAT32, 1'b0, lat);
    op32("smax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, LAT32, 1'b0, lat);
    op32("mneg2", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, LAT32, 1'b0, lat);
    op32("mnegx1", 32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000, LAT32, 1'b0, lat);
    op32("u_mneg2", 32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000, LAT32, 1'b0, lat);
    op32("zero", 32'h00000000, 32'h12345678, 1'b1, 64'd0, LAT32, 1'b0, lat);

    // Operands and mode toggled every cycle while busy
    op32("scramble", 32'h0001_2345, 32'hFFFF_0F0F, 1'b1,
         ref32(32'h0001_2345, 32'hFFFF_0F0F, 1'b1), LAT32, 1'b1, lat);

    // Random 32-bit operands, both modes
    for (int k = 0; k < 24; k++) begin
      rq = $urandom; rb = $urandom;
      op32($sformatf("rnd%0d", k), rq, rb, 1'(k % 2), ref32(rq, rb, 1'(k % 2)), LAT32,
           1'(k % 3 == 0), lat);
    end

    // start held high: next op starts only after each done
    @(negedge clk);
    q32 = 32'hDEAD_BEEF; b32 = 32'h0000_0013; sg32 = 1'b1; start32 = 1'b1;
    sb32.push_back(ref32(32'hDEAD_BEEF, 32'h0000_0013, 1'b1));
    @(negedge clk);
    n = 0;
    while (done32 !== 1'b1 && n < 60) begin
      if (n == 4) begin q32 = 32'h1111_1111; b32 = 32'h2222_2222; end
      @(negedge clk);
      n++;
    end
    if (LAT32 > 0) check_int("held/lat_a", n, LAT32);
    check64("held/z_a", z32, sb32.pop_front());
    q32 = 32'h0000_0100; b32 = 32'hFFFF_FFFF; sg32 = 1'b0;
    sb32.push_back(ref32(32'h0000_0100, 32'hFFFF_FFFF, 1'b0));
    @(negedge clk);
    check64("held/busy_restart", 64'(busy32), 64'd1);
    n = 0;
    while (done32 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    start32 = 1'b0;
    if (LAT32 > 0) check_int("held/lat_b", n, LAT32);
    check64("held/z_b", z32, sb32.pop_front());
    @(negedge clk);
    @(negedge clk);
    check64("held/idle_after", 64'(busy32), 64'd0);

    // Reset pulsed mid-operation
    @(negedge clk);
    q32 = 32'h0000_0003; b32 = 32'h0000_0005; sg32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (8) @(negedge clk);
    check64("abort/busy_before", 64'(busy32), 64'd1);
    reset_n = 1'b0;
    #1;
    check64("abort/busy", 64'(busy32), 64'd0);
    check64("abort/done", 64'(done32), 64'd0);
    check64("abort/z", z32, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done32 === 1'b1) seen++;
    end
    check_int("abort/no_done", seen, 0);
    check64("abort/z_held", z32, 64'd0);
    op32("after_abort", 32'h0000_0003, 32'h0000_0005, 1'b0, 64'd15, LAT32, 1'b0, lat);

`ifdef BOOTH_SEQ_MUL_EARLY_TERM_EN
    op32("et_5x3", 32'd5, 32'd3, 1'b1, 64'd15, 3, 1'b0, lat);
    op32("et_neg1", 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 64'hFFFFFFFF_FFFFEDCC, -1, 1'b0, lat);
    check_int("et_neg1/early", int'(lat < FULL32), 1);
    op32("et_top", 32'h0000_0007, 32'h4000_0000, 1'b1, 64'h00000001_C0000000, -1, 1'b0, lat);
    check_int("et_top/late", int'(lat >= FULL32 - 1), 1);
`endif

    // WIDTH=8: corner pairs in both modes, then random pairs
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        for (int s = 0; s < 2; s++)
          op8(corners[i], corners[j], 1'(s));
    for (int k = 0; k < 400; k++)
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
